// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the RV32M sequential multiply controller:
// op encodings, FSM states and the result latencies.
package mul_ctrl_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P0   = 3'd1,
        ST_P1   = 3'd2,
        ST_P2   = 3'd3,
        ST_P3   = 3'd4,
        ST_FIX  = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    // Edges from the accept edge (counted as the first) until resp_valid is high
    localparam int unsigned MUL_LAT_LO = 5;
    localparam int unsigned MUL_LAT_HI = 6;

endpackage

// File: rtl/mul16.sv
// Unsigned 16x16 -> 32 multiplier core shared across the partial-product steps.
module mul16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    assign p = a * b;

endmodule

// File: rtl/mul_sign_unit.sv
// Operand magnitude and result-sign generation for MUL/MULH/MULHSU/MULHU.
module mul_sign_unit
    import mul_ctrl_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] mag1,
    output logic [31:0] mag2,
    output logic        neg
);

    logic sign1;
    logic sign2;

    always_comb begin
        sign1 = rs1[31] && ((op == MUL_OP_MULH) || (op == MUL_OP_MULHSU));
        sign2 = rs2[31] && (op == MUL_OP_MULH);
        // Two's complement of 0x80000000 is itself, which is the correct unsigned magnitude
        mag1  = sign1 ? (~rs1 + 32'd1) : rs1;
        mag2  = sign2 ? (~rs2 + 32'd1) : rs2;
        neg   = sign1 ^ sign2;
    end

endmodule

// File: rtl/mul32_seq_ctrl.sv
// RV32M multiply sequencer: four 16x16 partial products accumulated into a
// 64-bit register over several cycles, then sign fix-up and handshake.
module mul32_seq_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag
);

    state_t           state;
    mul_op_t          op_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic             neg_q;
    logic [63:0]      acc;

    logic [31:0]      mag1;
    logic [31:0]      mag2;
    logic             neg;

    logic [15:0]      core_a;
    logic [15:0]      core_b;
    logic [31:0]      core_p;
    logic [63:0]      pp;
    logic [63:0]      acc_fix;

    mul_sign_unit u_sign (
        .op   (req_op),
        .rs1  (req_rs1),
        .rs2  (req_rs2),
        .mag1 (mag1),
        .mag2 (mag2),
        .neg  (neg)
    );

    mul16 u_mul (
        .a (core_a),
        .b (core_b),
        .p (core_p)
    );

    // Operand half selection and partial-product alignment follow the step
    always_comb begin
        core_a = '0;
        core_b = '0;
        pp     = '0;
        case (state)
            ST_P0: begin
                core_a = a_q[15:0];
                core_b = b_q[15:0];
                pp     = {32'd0, core_p};
            end
            ST_P1: begin
                core_a = a_q[15:0];
                core_b = b_q[31:16];
                pp     = {16'd0, core_p, 16'd0};
            end
            ST_P2: begin
                core_a = a_q[31:16];
                core_b = b_q[15:0];
                pp     = {16'd0, core_p, 16'd0};
            end
            ST_P3: begin
                core_a = a_q[31:16];
                core_b = b_q[31:16];
                pp     = {core_p, 32'd0};
            end
            default: ;
        endcase
    end

    assign acc_fix = neg_q ? (~acc + 64'd1) : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= MUL_OP_MUL;
            tag_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            neg_q      <= 1'b0;
            acc        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_tag   <= '0;
        end else if (flush) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q      <= mul_op_t'(req_op);
                        tag_q     <= req_tag;
                        a_q       <= mag1;
                        b_q       <= mag2;
                        neg_q     <= neg;
                        acc       <= '0;
                        req_ready <= 1'b0;
                        state     <= ST_P0;
                    end
                end
                ST_P0: begin
                    acc   <= acc + pp;
                    state <= ST_P1;
                end
                ST_P1: begin
                    acc   <= acc + pp;
                    state <= ST_P2;
                end
                ST_P2: begin
                    acc   <= acc + pp;
                    // The AH*BH term lands entirely above bit 31, so MUL never needs it
                    state <= (op_q == MUL_OP_MUL) ? ST_FIX : ST_P3;
                end
                ST_P3: begin
                    acc   <= acc + pp;
                    state <= ST_FIX;
                end
                ST_FIX: begin
                    acc        <= acc_fix;
                    resp_data  <= (op_q == MUL_OP_MUL) ? acc_fix[31:0] : acc_fix[63:32];
                    resp_tag   <= tag_q;
                    resp_valid <= 1'b1;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Self-checking bench for mul32_seq_ctrl: directed corner cases plus random
// operations compared against a 64-bit arithmetic reference.
module tb_mul32_seq_ctrl;
    import mul_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;

    int vectors = 0;
    int miscompares = 0;

    mul32_seq_ctrl #(.TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: extend each operand to 64 bits by its signedness, multiply mod 2^64
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] xa;
        logic [63:0] xb;
        logic [63:0] p;
        xa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = xa * xb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Starts and ends at a negedge; a call right after another is back-to-back
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] exp, input int hold,
                          input bit flush_at_done);
        int lat;
        chk("ready_before_req", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = tag;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_rs1   = $urandom;
        req_rs2   = $urandom;
        req_tag   = 5'($urandom);
        chk("busy_ready_low", {63'd0, req_ready}, 64'd0);
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", 64'(lat), 64'((op == 2'b00) ? MUL_LAT_LO : MUL_LAT_HI));
        chk("resp_data", {32'd0, resp_data}, {32'd0, exp});
        chk("resp_tag", {59'd0, resp_tag}, {59'd0, tag});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {63'd0, resp_valid}, 64'd1);
            chk("hold_data", {32'd0, resp_data}, {32'd0, exp});
            chk("hold_tag", {59'd0, resp_tag}, {59'd0, tag});
            chk("hold_ready", {63'd0, req_ready}, 64'd0);
        end
        resp_ready = 1'b1;
        flush      = flush_at_done;
        @(negedge clk);
        resp_ready = 1'b0;
        flush      = 1'b0;
        chk("valid_drop", {63'd0, resp_valid}, 64'd0);
        chk("ready_back", {63'd0, req_ready}, 64'd1);
    endtask

    task automatic quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk(tag, {62'd0, resp_valid, req_ready}, 64'd1);
        end
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_rs1    = '0;
        req_rs2    = '0;
        req_tag    = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_data", {32'd0, resp_data}, 64'd0);
        chk("rst_resp_tag", {59'd0, resp_tag}, 64'd0);

        run_op(2'b00, 32'd3, 32'd5, 5'd9, 32'h0000000F, 0, 1'b0);
        run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE, 0, 1'b0);
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000001, 0, 1'b0);
        run_op(2'b01, 32'h80000000, 32'h80000000, 5'd3, 32'h40000000, 0, 1'b0);
        run_op(2'b01, 32'hFFFFFFFF, 32'h00000001, 5'd4, 32'hFFFFFFFF, 0, 1'b0);
        run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'hFFFFFFFF, 0, 1'b0);
        run_op(2'b01, 32'h00000000, 32'h80000000, 5'd6, 32'h00000000, 0, 1'b0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd7, 32'h80000000, 0, 1'b0);
        // Stalled consumer followed by an immediate back-to-back request
        run_op(2'b11, 32'h12345678, 32'h9ABCDEF0, 5'd17, 32'h0B00EA4E, 3, 1'b0);
        run_op(2'b01, 32'hFFFFFFFE, 32'h00000003, 5'd18, 32'hFFFFFFFF, 0, 1'b0);

        // Flush during P1
        req_valid = 1'b1;
        req_op    = 2'b11;
        req_rs1   = 32'hDEADBEEF;
        req_rs2   = 32'h0BADF00D;
        req_tag   = 5'd21;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_p1_ready", {63'd0, req_ready}, 64'd1);
        quiet("flush_p1_quiet", 8);

        // Reset during P2
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_rs1   = 32'h7FFFFFFF;
        req_rs2   = 32'h7FFFFFFF;
        req_tag   = 5'd22;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_p2_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_p2_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_p2_data", {32'd0, resp_data}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        quiet("rst_p2_quiet", 8);
        run_op(2'b00, 32'd7, 32'd6, 5'd23, 32'h0000002A, 0, 1'b0);

        // Flush collides with req_valid in IDLE: request must be dropped
        req_valid = 1'b1;
        flush     = 1'b1;
        req_op    = 2'b00;
        req_rs1   = 32'd2;
        req_rs2   = 32'd2;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        quiet("flush_idle_quiet", 8);

        // Flush together with resp_ready in DONE drops the response
        run_op(2'b00, 32'd100, 32'd100, 5'd24, 32'd10000, 1, 1'b1);
        quiet("flush_done_quiet", 3);

        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom);
            case ($urandom_range(0, 3))
                0: a = 32'h80000000;
                1: a = $urandom_range(0, 15);
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : $urandom;
            run_op(op, a, b, 5'($urandom), model(op, a, b), $urandom_range(0, 2), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
